user_out_drop_filter: RTL and testbench

Sits directly downstream of the user SDNet wrapper and consumes its AXI-Stream output, which carries a 304-bit tuser (256-bit digest over a 48-bit SUME header). It discards whole packets marked for drop or with no destination, and forwards all other packets with tuser repacked into the 128-bit SUME format: the low 80 digest bits replace the queue-size fields. A two-entry skid buffer registers every output and breaks the tready path toward the SDNet core.

---
 rtl/user_out_drop_filter.sv | 169 ++++++++++++++++
 tb/tb_user_out_drop_filter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_out_drop_filter.sv
// Drops SDNet packets that are flagged for drop or have no destination, repacks tuser into the
// 128-bit SUME format and registers the output through a two-entry skid buffer.
// Optional packet counters are built when USER_OUT_STATS_EN is defined.
module user_out_drop_filter #(
  parameter int C_AXIS_DATA_WIDTH    = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 304,
  parameter int C_M_AXIS_TUSER_WIDTH = 128
) (
  input  logic                              axis_aclk,
  input  logic                              axis_resetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [31:0]                       fwd_pkt_count,
  output logic [31:0]                       drop_pkt_count
);

  localparam int KW = C_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_M_AXIS_TUSER_WIDTH;
  localparam int BW = C_AXIS_DATA_WIDTH + KW + UW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            readyEn_q;
  logic            outValid_q, outValid_d;
  logic            skidValid_q, skidValid_d;
  logic [BW-1:0]   outBeat_q, outBeat_d;
  logic [BW-1:0]   skidBeat_q, skidBeat_d;
  logic [BW-1:0]   inBeat;
  logic [UW-1:0]   beatUser;
  logic            inAccept;
  logic            firstDrop;
  logic            pushBeat;
  logic            dropLast;
  logic            unused_tuser;

  // readyEn_q keeps tready low through reset and for the cycle it is released in.
  assign s_axis_tready = readyEn_q & ((state_q == DROP) | ~skidValid_q);
  assign inAccept      = s_axis_tvalid & s_axis_tready;
  assign firstDrop     = s_axis_tuser[32] | (s_axis_tuser[31:24] == 8'h00);
  assign inBeat        = {s_axis_tdata, s_axis_tkeep, beatUser, s_axis_tlast};
  assign unused_tuser  = ^s_axis_tuser[C_S_AXIS_TUSER_WIDTH-1:UW];

  always_comb begin
    state_d  = state_q;
    pushBeat = 1'b0;
    dropLast = 1'b0;
    beatUser = '0;
    case (state_q)
      IDLE: begin
        if (inAccept) begin
          if (firstDrop) begin
            if (s_axis_tlast) dropLast = 1'b1;
            else              state_d  = DROP;
          end else begin
            pushBeat = 1'b1;
            beatUser = s_axis_tuser[UW-1:0];
            if (!s_axis_tlast) state_d = FWD;
          end
        end
      end
      FWD: begin
        if (inAccept) begin
          pushBeat = 1'b1;
          if (s_axis_tlast) state_d = IDLE;
        end
      end
      DROP: begin
        if (inAccept && s_axis_tlast) begin
          dropLast = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The skid entry always drains into the output register before a new beat, keeping order.
  always_comb begin
    outValid_d  = outValid_q;
    outBeat_d   = outBeat_q;
    skidValid_d = skidValid_q;
    skidBeat_d  = skidBeat_q;
    if (!outValid_q || m_axis_tready) begin
      if (skidValid_q) begin
        outValid_d  = 1'b1;
        outBeat_d   = skidBeat_q;
        skidValid_d = pushBeat;
        if (pushBeat) skidBeat_d = inBeat;
      end else begin
        outValid_d = pushBeat;
        if (pushBeat) outBeat_d = inBeat;
      end
    end else if (pushBeat) begin
      skidValid_d = 1'b1;
      skidBeat_d  = inBeat;
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q     <= IDLE;
      readyEn_q   <= 1'b0;
      outValid_q  <= 1'b0;
      outBeat_q   <= '0;
      skidValid_q <= 1'b0;
      skidBeat_q  <= '0;
    end else begin
      state_q     <= state_d;
      readyEn_q   <= 1'b1;
      outValid_q  <= outValid_d;
      outBeat_q   <= outBeat_d;
      skidValid_q <= skidValid_d;
      skidBeat_q  <= skidBeat_d;
    end
  end

  assign m_axis_tvalid = outValid_q;
  assign m_axis_tlast  = outBeat_q[0];
  assign m_axis_tuser  = outBeat_q[UW:1];
  assign m_axis_tkeep  = outBeat_q[UW+KW:UW+1];
  assign m_axis_tdata  = outBeat_q[BW-1:UW+KW+1];

`ifdef USER_OUT_STATS_EN
  logic [31:0] fwdCnt_q, fwdCnt_d;
  logic [31:0] dropCnt_q, dropCnt_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    fwdCnt_d  = fwdCnt_q;
    dropCnt_d = dropCnt_q;
    if (pushBeat && s_axis_tlast && (fwdCnt_q != 32'hFFFF_FFFF)) fwdCnt_d = fwdCnt_q + 32'd1;
    if (dropLast && (dropCnt_q != 32'hFFFF_FFFF)) dropCnt_d = dropCnt_q + 32'd1;
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      fwdCnt_q  <= 32'h0;
      dropCnt_q <= 32'h0;
    end else begin
      fwdCnt_q  <= fwdCnt_d;
      dropCnt_q <= dropCnt_d;
    end
  end

  assign fwd_pkt_count  = fwdCnt_q;
  assign drop_pkt_count = dropCnt_q;
`else
  logic unused_stats;
  assign unused_stats   = dropLast;
  assign fwd_pkt_count  = 32'h0;
  assign drop_pkt_count = 32'h0;
`endif

endmodule

// File: tb/tb_user_out_drop_filter.sv
// Randomized bench for user_out_drop_filter: a packet-level scoreboard plus directed cases.
// Counter expectations follow USER_OUT_STATS_EN.
module tb_user_out_drop_filter;

  localparam int DW  = 256;
  localparam int KW  = 32;
  localparam int SUW = 304;
  localparam int MUW = 128;
  localparam int BW  = DW + KW + MUW + 1;

  logic            axis_aclk = 1'b0;
  logic            axis_resetn = 1'b0;
  logic [DW-1:0]   s_axis_tdata = '0;
  logic [KW-1:0]   s_axis_tkeep = '0;
  logic [SUW-1:0]  s_axis_tuser = '0;
  logic            s_axis_tvalid = 1'b0;
  logic            s_axis_tready;
  logic            s_axis_tlast = 1'b0;
  logic [DW-1:0]   m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep;
  logic [MUW-1:0]  m_axis_tuser;
  logic            m_axis_tvalid;
  logic            m_axis_tready = 1'b1;
  logic            m_axis_tlast;
  logic [31:0]     fwd_pkt_count;
  logic [31:0]     drop_pkt_count;

  always #5 axis_aclk = ~axis_aclk;

  user_out_drop_filter dut (
    .axis_aclk      (axis_aclk),
    .axis_resetn    (axis_resetn),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tuser   (s_axis_tuser),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .fwd_pkt_count  (fwd_pkt_count),
    .drop_pkt_count (drop_pkt_count)
  );

  int checkCount = 0;
  int passCount  = 0;
  int readyMode  = 1;
  logic [BW-1:0] expQ[$];
  logic [31:0]   modelFwd  = 32'h0;
  logic [31:0]   modelDrop = 32'h0;

  task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
  endtask

  function automatic logic [31:0] satInc(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  function automatic logic [31:0] statsView(input logic [31:0] m);
`ifdef USER_OUT_STATS_EN
    return m;
`else
    return (m & 32'h0);
`endif
  endfunction

  function automatic logic [319:0] randWide();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Present one beat and hold it until the DUT accepts it; returns at the accepting edge.
  task automatic applyStimulus(input logic [DW-1:0] d, input logic [KW-1:0] k,
                               input logic [SUW-1:0] u, input logic l, output int waited);
    @(negedge axis_aclk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    #1;
    waited = 0;
    while (!s_axis_tready && waited < 500) begin
      @(negedge axis_aclk);
      #1;
      waited++;
    end
    if (!s_axis_tready) begin
      checkOutput("inputReadyTimeout", {511'b0, s_axis_tready}, 512'd1);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $fatal(1, "[TB] input handshake never completed");
    end
    @(posedge axis_aclk);
  endtask

  task automatic idleCycles(input int n);
    logic [319:0] r;
    repeat (n) begin
      @(negedge axis_aclk);
      r = randWide();
      s_axis_tvalid = 1'b0;
      s_axis_tuser  = r[SUW-1:0];
    end
  endtask

  task automatic sendPacket(input int len, input logic [7:0] dst, input logic dropBit, input int maxGap);
    logic [319:0]   r;
    logic [SUW-1:0] u, ub;
    logic [DW-1:0]  d;
    logic [KW-1:0]  k;
    logic [MUW-1:0] eu;
    logic           fwd;
    logic           last;
    int             waited;
    r = randWide();
    u = r[SUW-1:0];
    u[31:24] = dst;
    u[32]    = dropBit;
    fwd = !dropBit && (dst != 8'h00);
    for (int i = 0; i < len; i++) begin
      if (maxGap > 0) idleCycles($urandom_range(0, maxGap));
      r = randWide(); d = r[DW-1:0];
      r = randWide(); k = r[KW-1:0];
      r = randWide(); ub = (i == 0) ? u : r[SUW-1:0];
      eu = (i == 0) ? u[MUW-1:0] : {MUW{1'b0}};
      last = (i == len - 1);
      applyStimulus(d, k, ub, last, waited);
      if (fwd) expQ.push_back({d, k, eu, last});
      if (!fwd && i > 0) checkOutput("dropReadyHigh", {511'b0, waited == 0}, 512'd1);
      if (last) begin
        if (fwd) modelFwd  = satInc(modelFwd);
        else     modelDrop = satInc(modelDrop);
      end
    end
  endtask

  // Output side: drives m_axis_tready, pops the scoreboard on every transfer, checks AXIS hold
  // rules and the counters every cycle.
  initial begin : monitor
    logic [BW-1:0] prevBeat, curBeat, expBeat;
    logic          prevStall;
    prevStall = 1'b0;
    prevBeat  = '0;
    forever begin
      @(negedge axis_aclk);
      m_axis_tready = (readyMode == 1) ? 1'b1 :
                      (readyMode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
      #1;
      if (!axis_resetn) begin
        prevStall = 1'b0;
        continue;
      end
      curBeat = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
      if (prevStall) checkOutput("holdStable", {m_axis_tvalid, curBeat}, {1'b1, prevBeat});
      if (m_axis_tvalid && m_axis_tready) begin
        checkOutput("beatExpected", {511'b0, expQ.size() != 0}, 512'd1);
        if (expQ.size() != 0) begin
          expBeat = expQ.pop_front();
          checkOutput("outBeat", curBeat, expBeat);
        end
      end
      prevStall = m_axis_tvalid && !m_axis_tready;
      prevBeat  = curBeat;
      checkOutput("fwdCount", fwd_pkt_count, statsView(modelFwd));
      checkOutput("dropCount", drop_pkt_count, statsView(modelDrop));
    end
  end

  task automatic releaseInput();
    @(negedge axis_aclk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    releaseInput();
    while (expQ.size() != 0 && n < 300) begin
      @(negedge axis_aclk);
      n++;
    end
    repeat (2) @(negedge axis_aclk);
    checkOutput(name, expQ.size(), 512'd0);
  endtask

  initial begin : main
    logic [SUW-1:0] u;
    logic [319:0]   r;
    logic [DW-1:0]  d;
    int             w;

    // Reset state
    repeat (2) @(negedge axis_aclk);
    #1;
    checkOutput("resetOutputs", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast}, 512'd0);
    checkOutput("resetReady", {511'b0, s_axis_tready}, 512'd0);
    checkOutput("resetCounters", {fwd_pkt_count, drop_pkt_count}, 512'd0);
    @(negedge axis_aclk);
    axis_resetn = 1'b1;
    @(posedge axis_aclk);
    @(negedge axis_aclk);
    #1;
    checkOutput("readyAfterReset", {511'b0, s_axis_tready}, 512'd1);

    // Three-beat forwarded packet, one-cycle latency, repacked tuser
    $display("[TB] directed: three-beat forward");
    readyMode = 1;
    r = randWide();
    u = r[SUW-1:0];
    u[127:0] = 128'h0123_4567_89AB_CDEF_0123_0000_0100_0000;
    d = {8{32'h1111_1111}};
    applyStimulus(d, {KW{1'b1}}, u, 1'b0, w);
    expQ.push_back({d, {KW{1'b1}}, 128'h0123_4567_89AB_CDEF_0123_0000_0100_0000, 1'b0});
    @(negedge axis_aclk);
    s_axis_tvalid = 1'b0;
    #1;
    checkOutput("latencyValid", {511'b0, m_axis_tvalid}, 512'd1);
    checkOutput("firstUser", m_axis_tuser, 512'h0123_4567_89AB_CDEF_0123_0000_0100_0000);
    for (int i = 1; i < 3; i++) begin
      r = randWide();
      d = (i == 1) ? {8{32'h2222_2222}} : {8{32'h3333_3333}};
      applyStimulus(d, {KW{1'b1}}, r[SUW-1:0], (i == 2), w);
      expQ.push_back({d, {KW{1'b1}}, {MUW{1'b0}}, (i == 2)});
    end
    modelFwd = satInc(modelFwd);
    drain("drainT1");
    checkOutput("fwdAfterT1", fwd_pkt_count, statsView(32'd1));

    // Dropped two-beat packet, then forwarded single-beat packet
    $display("[TB] directed: drop flag then forward");
    sendPacket(2, 8'h05, 1'b1, 0);
    sendPacket(1, 8'h04, 1'b0, 0);
    drain("drainT2");
    checkOutput("dropAfterT2", drop_pkt_count, statsView(32'd1));
    checkOutput("fwdAfterT2", fwd_pkt_count, statsView(32'd2));

    // Single-beat packet with no destination, then a forwarded packet
    $display("[TB] directed: zero destination");
    sendPacket(1, 8'h00, 1'b0, 0);
    sendPacket(2, 8'h10, 1'b0, 0);
    drain("drainT3");
    checkOutput("dropAfterT3", drop_pkt_count, statsView(32'd2));
    checkOutput("fwdAfterT3", fwd_pkt_count, statsView(32'd3));

    // Four-beat packet with a three-cycle downstream stall mid-packet
    $display("[TB] directed: downstream stall");
    r = randWide();
    u = r[SUW-1:0];
    u[31:24] = 8'h22;
    u[32]    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      r = randWide();
      d = r[DW-1:0];
      applyStimulus(d, {KW{1'b1}}, (i == 0) ? u : r[SUW-1:0], 1'b0, w);
      expQ.push_back({d, {KW{1'b1}}, (i == 0) ? u[MUW-1:0] : {MUW{1'b0}}, 1'b0});
    end
    readyMode = 2;
    fork
      begin
        logic [DW-1:0] dd;
        logic [319:0]  rr;
        int            ww;
        for (int i = 2; i < 4; i++) begin
          rr = randWide();
          dd = rr[DW-1:0];
          applyStimulus(dd, {KW{1'b1}}, rr[SUW-1:0], (i == 3), ww);
          expQ.push_back({dd, {KW{1'b1}}, {MUW{1'b0}}, (i == 3)});
        end
      end
      begin
        repeat (3) @(negedge axis_aclk);
        #1;
        checkOutput("stallReadyLow", {511'b0, s_axis_tready}, 512'd0);
        readyMode = 1;
      end
    join
    modelFwd = satInc(modelFwd);
    drain("drainT4");

    // Reset pulsed during a stalled packet
    $display("[TB] directed: reset mid-packet");
    readyMode = 2;
    r = randWide();
    u = r[SUW-1:0];
    u[31:24] = 8'h33;
    u[32]    = 1'b0;
    applyStimulus(r[DW-1:0], {KW{1'b1}}, u, 1'b0, w);
    r = randWide();
    applyStimulus(r[DW-1:0], {KW{1'b1}}, r[SUW-1:0], 1'b0, w);
    @(negedge axis_aclk);
    s_axis_tvalid = 1'b0;
    axis_resetn   = 1'b0;
    modelFwd      = 32'h0;
    modelDrop     = 32'h0;
    #1;
    checkOutput("midResetOutputs", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast}, 512'd0);
    checkOutput("midResetReady", {511'b0, s_axis_tready}, 512'd0);
    checkOutput("midResetCounters", {fwd_pkt_count, drop_pkt_count}, 512'd0);
    repeat (2) @(negedge axis_aclk);
    axis_resetn = 1'b1;
    readyMode   = 1;
    @(posedge axis_aclk);
    @(negedge axis_aclk);
    #1;
    checkOutput("readyAfterMidReset", {511'b0, s_axis_tready}, 512'd1);
    sendPacket(3, 8'h44, 1'b0, 0);
    drain("drainT5");
    checkOutput("fwdAfterT5", fwd_pkt_count, statsView(32'd1));

    // Randomized traffic with random backpressure and gaps
    $display("[TB] random traffic");
    readyMode = 0;
    for (int p = 0; p < 80; p++) begin
      logic [7:0] dst;
      dst = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      sendPacket($urandom_range(1, 5), dst, ($urandom_range(0, 3) == 0), (p % 3));
    end
    readyMode = 1;
    drain("drainRandom");

`ifdef USER_OUT_STATS_EN
    // Saturation of the drop counter from a preloaded value
    $display("[TB] drop counter saturation");
    @(negedge axis_aclk);
    force dut.dropCnt_q = 32'hFFFF_FFFE;
    modelDrop = 32'hFFFF_FFFE;
    #2;
    release dut.dropCnt_q;
    for (int p = 0; p < 5; p++) sendPacket(1 + (p % 2), 8'h00, (p % 2) == 1, 0);
    drain("drainSat");
    checkOutput("dropSaturated", drop_pkt_count, 512'hFFFF_FFFF);
`else
    checkOutput("noStatsFwd", fwd_pkt_count, 512'd0);
    checkOutput("noStatsDrop", drop_pkt_count, 512'd0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
